// File: rtl/branch_redirect_ctrl_if.sv
// Redirect-control bundle: EX-stage resolve inputs, fetch stall, and the PC redirect/flush/statistics outputs.
interface branch_redirect_ctrl_if #(
    parameter int CNT_W = 32
);
    logic              ex_valid;
    logic              ex_branch;
    logic              ex_taken;
    logic              ex_jump;
    logic [31:0]       ex_target;
    logic              if_stall;
    logic              pc_redirect;
    logic [31:0]       redirect_pc;
    logic              flush;
    logic              misalign_err;
    logic              busy;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  br_taken_count;
    logic [CNT_W-1:0]  jump_count;

    modport master (
        input  ex_valid, ex_branch, ex_taken, ex_jump, ex_target, if_stall,
        output pc_redirect, redirect_pc, flush, misalign_err, busy,
               br_count, br_taken_count, jump_count
    );

    modport slave (
        output ex_valid, ex_branch, ex_taken, ex_jump, ex_target, if_stall,
        input  pc_redirect, redirect_pc, flush, misalign_err, busy,
               br_count, br_taken_count, jump_count
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Sequences predict-not-taken redirects: PC redirect pulse, pipeline flush, branch/jump statistics.
// Latency: redirect pulse 1 cycle after the sampled resolve; all outputs registered.
// Backpressure: if_stall parks the redirect in PENDING with flush held until fetch can accept it.
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [2:0]       FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state_q, state_d;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic              pc_redirect_q, pc_redirect_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  br_taken_cnt_q, br_taken_cnt_d;
    logic [CNT_W-1:0]  jump_cnt_q, jump_cnt_d;

    logic              resolve;
    logic [31:0]       eff_target;

    // JALR semantics: bit 0 of the target is always discarded.
    assign eff_target = bus.ex_target & ~32'h1;
    assign resolve    = bus.ex_valid & (bus.ex_jump | (bus.ex_branch & bus.ex_taken));

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        pc_redirect_d  = 1'b0;
        redirect_pc_d  = redirect_pc_q;
        flush_d        = 1'b0;
        misalign_d     = 1'b0;
        br_cnt_d       = br_cnt_q;
        br_taken_cnt_d = br_taken_cnt_q;
        jump_cnt_d     = jump_cnt_q;

        case (state_q)
            IDLE: begin
                // A jump flagged as a branch too counts only as a jump.
                if (bus.ex_valid) begin
                    if (bus.ex_jump) begin
                        jump_cnt_d = jump_cnt_q + CNT_ONE;
                    end else if (bus.ex_branch) begin
                        br_cnt_d = br_cnt_q + CNT_ONE;
                        if (bus.ex_taken) begin
                            br_taken_cnt_d = br_taken_cnt_q + CNT_ONE;
                        end
                    end
                end
                if (resolve) begin
                    if (eff_target[1]) begin
                        misalign_d = 1'b1;
                    end else begin
                        redirect_pc_d = eff_target;
                        flush_d       = 1'b1;
                        if (bus.if_stall) begin
                            state_d = PENDING;
                        end else begin
                            pc_redirect_d = 1'b1;
                            flush_cnt_d   = FLUSH_LAST;
                            state_d       = FLUSH;
                        end
                    end
                end
            end
            PENDING: begin
                flush_d = 1'b1;
                if (!bus.if_stall) begin
                    pc_redirect_d = 1'b1;
                    flush_cnt_d   = FLUSH_LAST;
                    state_d       = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q != 3'd0) begin
                    flush_d     = 1'b1;
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            flush_cnt_q    <= 3'd0;
            pc_redirect_q  <= 1'b0;
            redirect_pc_q  <= 32'd0;
            flush_q        <= 1'b0;
            misalign_q     <= 1'b0;
            busy_q         <= 1'b0;
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
            jump_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            pc_redirect_q  <= pc_redirect_d;
            redirect_pc_q  <= redirect_pc_d;
            flush_q        <= flush_d;
            misalign_q     <= misalign_d;
            busy_q         <= busy_d;
            br_cnt_q       <= br_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
            jump_cnt_q     <= jump_cnt_d;
        end
    end

    assign bus.pc_redirect    = pc_redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_q;
    assign bus.misalign_err   = misalign_q;
    assign bus.busy           = busy_q;
    assign bus.br_count       = br_cnt_q;
    assign bus.br_taken_count = br_taken_cnt_q;
    assign bus.jump_count     = jump_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: reset, taken branch, stalled jump, wrong-path, misalign, mid-pending reset.
module tb_branch_redirect_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    branch_redirect_ctrl_if #(.CNT_W(32)) bus ();

    branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic b, input logic t, input logic j,
                         input logic [31:0] tgt, input logic st);
        bus.ex_valid  = v;
        bus.ex_branch = b;
        bus.ex_taken  = t;
        bus.ex_jump   = j;
        bus.ex_target = tgt;
        bus.if_stall  = st;
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] br,
                             input logic [31:0] bt, input logic [31:0] jp);
        chk32({tag, "_br"}, bus.br_count, br);
        chk32({tag, "_bt"}, bus.br_taken_count, bt);
        chk32({tag, "_jp"}, bus.jump_count, jp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset with random EX activity
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 32'($urandom) & ~32'h2, 1'($urandom_range(0, 1)));
            tick();
        end
        chk1("rst_redirect", bus.pc_redirect, 1'b0);
        chk1("rst_flush", bus.flush, 1'b0);
        chk1("rst_misalign", bus.misalign_err, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk32("rst_rpc", bus.redirect_pc, 32'h0);
        chk_stats("rst", 32'd0, 32'd0, 32'd0);

        // Not-taken branches: counted, never redirect
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0080, 1'($urandom_range(0, 1)));
            tick();
            chk1("nt_redirect", bus.pc_redirect, 1'b0);
            chk1("nt_flush", bus.flush, 1'b0);
        end
        chk_stats("nt", 32'd3, 32'd0, 32'd0);

        // Taken branch, no stall
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("tb_e1_redirect", bus.pc_redirect, 1'b1);
        chk32("tb_e1_rpc", bus.redirect_pc, 32'h0000_0040);
        chk1("tb_e1_flush", bus.flush, 1'b1);
        chk1("tb_e1_busy", bus.busy, 1'b1);
        chk_stats("tb", 32'd4, 32'd1, 32'd0);
        tick();
        chk1("tb_e2_redirect", bus.pc_redirect, 1'b0);
        chk1("tb_e2_flush", bus.flush, 1'b1);
        tick();
        chk1("tb_e3_flush", bus.flush, 1'b0);
        chk1("tb_e3_busy", bus.busy, 1'b0);

        // Stalled JALR; taken branches presented as wrong path throughout
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 1'b1);
        tick();
        chk1("st_flush0", bus.flush, 1'b1);
        chk1("st_busy0", bus.busy, 1'b1);
        chk1("st_redirect0", bus.pc_redirect, 1'b0);
        chk32("st_rpc0", bus.redirect_pc, 32'h0000_0100);
        chk_stats("st", 32'd4, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 1'b1);
            tick();
            chk1("st_flush", bus.flush, 1'b1);
            chk1("st_busy", bus.busy, 1'b1);
            chk1("st_redirect", bus.pc_redirect, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 1'b0);
        tick();
        chk1("st_rel_redirect", bus.pc_redirect, 1'b1);
        chk32("st_rel_rpc", bus.redirect_pc, 32'h0000_0100);
        chk1("st_rel_flush", bus.flush, 1'b1);
        tick();
        chk1("st_f1_redirect", bus.pc_redirect, 1'b0);
        chk1("st_f1_flush", bus.flush, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("st_end_flush", bus.flush, 1'b0);
        chk1("st_end_busy", bus.busy, 1'b0);
        chk1("st_end_redirect", bus.pc_redirect, 1'b0);
        chk_stats("wp", 32'd4, 32'd1, 32'd1);
        tick();
        chk1("wp_idle_redirect", bus.pc_redirect, 1'b0);
        chk1("wp_idle_flush", bus.flush, 1'b0);

        // Misaligned jump target
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0042, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("ma_err", bus.misalign_err, 1'b1);
        chk1("ma_redirect", bus.pc_redirect, 1'b0);
        chk1("ma_flush", bus.flush, 1'b0);
        chk1("ma_busy", bus.busy, 1'b0);
        chk32("ma_rpc_hold", bus.redirect_pc, 32'h0000_0100);
        chk_stats("ma", 32'd4, 32'd1, 32'd2);
        tick();
        chk1("ma_err_drop", bus.misalign_err, 1'b0);

        // Jump and branch both set: treated as jump only
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk1("jb_redirect", bus.pc_redirect, 1'b1);
        chk32("jb_rpc", bus.redirect_pc, 32'h0000_0080);
        chk_stats("jb", 32'd4, 32'd1, 32'd3);
        tick();
        tick();
        chk1("jb_end_busy", bus.busy, 1'b0);

        // Reset while PENDING abandons the redirect
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1);
        tick();
        chk1("rp_busy", bus.busy, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_stall = 1'b0;
        chk1("rp_flush", bus.flush, 1'b0);
        chk1("rp_busy0", bus.busy, 1'b0);
        chk32("rp_rpc", bus.redirect_pc, 32'h0);
        chk_stats("rp", 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rp_no_redirect", bus.pc_redirect, 1'b0);
            chk1("rp_no_flush", bus.flush, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
